// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian bytes into 32-bit words and
// writes them to instruction memory from BASE_ADDR. Optional csum port via IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_LOAD  | accepting stream bytes into the assembly register
// S_WRITE | one-cycle instruction-memory write of the assembled word
// S_DONE  | program loaded, waiting for start
// S_ERR   | load aborted (partial word or capacity overflow)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h28,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count,
    output logic [31:0] pc_entry
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] csum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;
    logic        last_word;
    logic        xfer;
    logic        launch;
    logic        word_full;

    assign pc_entry  = BASE_ADDR;
    // in_ready is exactly "state is LOAD", so use the state directly here
    assign xfer      = (state == S_LOAD) && in_valid;
    assign launch    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign word_full = (({1'b0, word_count} + 17'd1) == 17'(MAX_WORDS));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    if (byte_idx == 2'd3) state_nxt = S_WRITE;
                    else if (in_last)     state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                if (last_word)      state_nxt = S_DONE;
                else if (word_full) state_nxt = S_ERR;
                else                state_nxt = S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            asm_word   <= 24'd0;
            last_word  <= 1'b0;
            word_count <= 16'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 32'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (launch) begin
                byte_idx   <= 2'd0;
                asm_word   <= 24'd0;
                last_word  <= 1'b0;
                word_count <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= 32'd0;
`endif
            end
            if (xfer) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: asm_word[7:0]   <= in_data;
                    2'd1: asm_word[15:8]  <= in_data;
                    2'd2: asm_word[23:16] <= in_data;
                    default: begin
                        // the write port is loaded here so it is valid throughout WRITE
                        mem_we    <= 1'b1;
                        mem_wdata <= {in_data, asm_word};
                        mem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
                        last_word <= in_last;
                    end
                endcase
            end
            if (state == S_WRITE) begin
                word_count <= word_count + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= csum + mem_wdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads with random data and gaps,
// checked against a byte-stream reference model. Checks csum when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

    localparam int          MAXW = 4;
    localparam logic [31:0] BASE = 32'h28;

    typedef logic [8:0] stim_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr, mem_wdata, pc_entry;
    logic [15:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ready_bad = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error),
        .word_count(word_count), .pc_entry(pc_entry)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (in_ready !== 1'b0) ready_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic stim_q_t mk_stim(input logic [31:0] w[$]);
        stim_q_t s;
        for (int i = 0; i < w.size(); i++)
            for (int b = 0; b < 4; b++)
                s.push_back({1'b0, w[i][8*b +: 8]});
        if (s.size() > 0) s[s.size()-1][8] = 1'b1;
        return s;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input stim_q_t stim, input bit gaps, input string tag);
        logic [31:0] exp_w[$];
        logic [31:0] acc;
        logic [31:0] sum;
        bit          exp_done, exp_err;
        int          nb, guard;

        // reference: walk the byte stream and apply the framing/capacity rules directly
        exp_done = 0; exp_err = 0; acc = 0; nb = 0; sum = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (exp_done || exp_err) break;
            acc = acc | (32'(stim[i][7:0]) << (8 * nb));
            nb++;
            if (nb == 4) begin
                exp_w.push_back(acc);
                sum = sum + acc;
                acc = 0; nb = 0;
                if (stim[i][8])               exp_done = 1;
                else if (exp_w.size() == MAXW) exp_err = 1;
            end else if (stim[i][8]) begin
                exp_err = 1;
            end
        end

        wr_addr_q.delete();
        wr_data_q.delete();
        ready_bad = 0;
        pulse_start();
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_wc_start"}, 32'(word_count), 32'd0);

        for (int i = 0; i < stim.size(); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim[i][7:0];
            in_last  = stim[i][8];
            guard = 0;
            while (!in_ready && !done && !error && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        guard = 0;
        while (!done && !error && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_word_count"}, 32'(word_count), 32'(exp_w.size()));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_ready_end"}, 32'(in_ready), 32'd0);
        check({tag, "_num_writes"}, 32'(wr_addr_q.size()), 32'(exp_w.size()));
        check({tag, "_ready_in_write"}, 32'(ready_bad), 32'd0);
        for (int i = 0; i < exp_w.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_w[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check({tag, "_csum"}, csum, sum);
`endif
    endtask

    initial begin
        logic [31:0] w[$];
        stim_q_t     s;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("pc_entry", pc_entry, BASE);

        w = '{32'h00A00513};
        run_load(mk_stim(w), 1'b0, "single");

        w = '{$urandom(), $urandom(), $urandom()};
        run_load(mk_stim(w), 1'b1, "gaps");

        // partial word: stream ends on the 3rd byte of word 2
        w = '{$urandom(), $urandom()};
        s = mk_stim(w);
        s[s.size()-1][8] = 1'b0;
        void'(s.pop_back());
        s[s.size()-1][8] = 1'b1;
        run_load(s, 1'b0, "partial");

        w = '{$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        run_load(mk_stim(w), 1'b1, "overflow");

        // exactly MAXW words with last on the final byte: completes rather than overflows
        w = '{$urandom(), $urandom(), $urandom(), $urandom()};
        run_load(mk_stim(w), 1'b0, "full_last");

        // reset after two bytes of a word
        wr_addr_q.delete();
        pulse_start();
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_no_write", 32'(wr_addr_q.size()), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        w = '{32'h12345678};
        run_load(mk_stim(w), 1'b0, "after_rst");

        w = '{32'h00000001, 32'h00000002, 32'hFFFFFFFF};
        run_load(mk_stim(w), 1'b0, "csum_load");
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("csum_value", csum, 32'h00000002);
        pulse_start();
        check("csum_cleared", csum, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        for (int r = 0; r < 4; r++) begin
            w.delete();
            repeat ($urandom_range(1, 5)) w.push_back($urandom());
            run_load(mk_stim(w), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instructions into the CPU's instruction memory, the write side of the memory the fetch stage reads. It accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit RISC-V instruction words. It writes each word to consecutive word addresses starting at the program entry point. It reports completion, word count and errors, so the CPU can be released to fetch from `pc_entry`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h28: byte address of the first word written; also driven on `pc_entry`.
- `MAX_WORDS`, 64: capacity in words; legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only.
- `in_valid`  in  1  byte present on `in_data`.
- `in_data`  in  8  stream byte, least significant byte of each word first.
- `in_last`  in  1  marks the final byte of the program.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of the write, word aligned.
- `mem_wdata`  out  32  assembled instruction word.
- `busy`  out  1  high in LOAD and WRITE.
- `done`  out  1  program loaded successfully.
- `error`  out  1  load aborted.
- `word_count`  out  16  number of words written in the current or last load.
- `pc_entry`  out  32  constant `BASE_ADDR`.

## Operation
- States:
  - IDLE: `in_ready`=0; `start` -> LOAD.
  - LOAD: `in_ready`=1.
    - A byte transfers when `in_valid & in_ready` in the same cycle.
    - The byte goes into lane `byte_idx` (0..3); `byte_idx` then increments and wraps 3->0.
    - A transfer at `byte_idx`=3 -> WRITE.
    - A transfer with `in_last` at `byte_idx`≠3 -> ERR (partial word); nothing is written.
  - WRITE: one cycle; `in_ready`=0, `mem_we`=1.
    - `mem_addr` = `BASE_ADDR` + 4×`word_count` (32-bit wrap); `mem_wdata` = assembled word; `word_count` increments.
    - Next state is DONE if the 4th byte carried `in_last`.
    - Otherwise ERR if the incremented `word_count` == `MAX_WORDS`.
    - Otherwise LOAD.
  - DONE: `done`=1; `start` -> LOAD.
  - ERR: `error`=1; `start` -> LOAD.
- On leaving IDLE/DONE/ERR via `start`:
  - `word_count`, `byte_idx` and the assembly register clear to 0.
  - `done` and `error` clear.
- `start` in LOAD or WRITE is ignored.
- `in_valid` while `in_ready`=0 is not consumed; the producer holds `in_data` and `in_last` stable until the transfer.
- Reset:
  - Values: state IDLE, `word_count`=0, `byte_idx`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `in_ready`=0, `busy`=0, `done`=0, `error`=0.
  - Reset mid-load discards any partial word and issues no write.
  - `reset` has priority over `start` and the handshake in the same cycle.

## Timing
- `in_ready`, `busy`, `done` and `error` are decoded from the registered state with no combinational path from inputs.
- `mem_we`/`mem_addr`/`mem_wdata` are registered and valid in the WRITE cycle, i.e. the cycle after the 4th byte transfer.
- Peak throughput is 5 cycles per word: 4 byte transfers plus 1 WRITE.
- `done`/`error` assert the cycle after the terminating WRITE or transfer and hold until `start` or `reset`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Adds output `csum` [31:0], a running 32-bit wrap-around sum of every written `mem_wdata`.
  - It updates in the WRITE cycle (visible the next cycle), clears on `start`, and resets to 0.
  - The host compares it against its own sum once `done` is high.
- Not defined: port and adder are absent; all other behaviour is identical.

## Test plan
- Single-word load:
  - Stimulus: reset, `start`, bytes 13,05,A0,00 with `in_last` on 00.
  - Required: exactly one `mem_we` at `mem_addr`=0x28 with `mem_wdata`=0x00A00513; then `done`=1, `word_count`=1, `busy`=0.
- Backpressure and gaps:
  - Stimulus: three words, with `in_valid` dropped for 1–3 random cycles between bytes.
  - Required: writes at 0x28, 0x2C, 0x30 with the correct words; no byte is lost or duplicated; `in_ready`=0 in each WRITE cycle.
- Partial word:
  - Stimulus: `in_last` on the 3rd byte of the 2nd word.
  - Required: `error`=1; no second `mem_we`; `word_count`=1.
- Overflow:
  - Stimulus: `MAX_WORDS`=4, five words streamed.
  - Required: four writes (0x28–0x34), then `error`=1 with `in_ready`=0; `word_count`=4.
- Mid-load reset:
  - Stimulus: `reset` after 2 bytes, then `start` and a full word.
  - Required: no write before the reset completes; the new word is written at 0x28; `word_count`=1.
- Checksum, with `IMEM_LOADER_CHECKSUM_EN`:
  - Stimulus: load words 0x00000001, 0x00000002, 0xFFFFFFFF.
  - Required: `csum`=0x00000002 when `done`=1; a following `start` clears it to 0.
